// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for data-memory masters: port indices, grant encoding
// and the canonical memory request record.
package dmem_arbiter_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_AUX  = 2'd2
    } gnt_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// port and an auxiliary master that may hold the grant for bounded bursts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ready0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              ready1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } port_req_t;

    gnt_e              gnt_s;
    port_req_t         sel_s;
    logic              last_gnt_q, last_gnt_d;
    logic              lock_hold_q, lock_hold_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    // Grant decision: lock first (while under budget), then round-robin.
    always_comb begin
        gnt_s = GNT_NONE;
        if (reset) begin
            gnt_s = GNT_NONE;
        end else if (req0 && req1) begin
            if (lock_hold_q && (lock_cnt_q < MAX_LOCK_C)) begin
                gnt_s = GNT_AUX;
            end else if (last_gnt_q == PORT_CPU) begin
                gnt_s = GNT_AUX;
            end else begin
                gnt_s = GNT_CPU;
            end
        end else if (req0) begin
            gnt_s = GNT_CPU;
        end else if (req1) begin
            gnt_s = GNT_AUX;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Route the winner's operands to the memory and raise its ready.
    always_comb begin
        sel_s  = '{we: 1'b0, addr: {ADDR_W{1'b0}}, wdata: {DATA_W{1'b0}}};
        ready0 = 1'b0;
        ready1 = 1'b0;
        case (gnt_s)
            GNT_CPU: begin
                sel_s  = '{we: we0, addr: addr0, wdata: wdata0};
                ready0 = 1'b1;
            end
            GNT_AUX: begin
                sel_s  = '{we: we1, addr: addr1, wdata: wdata1};
                ready1 = 1'b1;
            end
            default: begin
                sel_s  = '{we: 1'b0, addr: {ADDR_W{1'b0}}, wdata: {DATA_W{1'b0}}};
                ready0 = 1'b0;
                ready1 = 1'b0;
            end
        endcase
    end

    assign mem_we    = sel_s.we;
    assign mem_addr  = sel_s.addr;
    assign mem_wdata = sel_s.wdata;

    // Next arbitration state and read-return capture.
    always_comb begin
        last_gnt_d  = last_gnt_q;
        lock_hold_d = 1'b0;
        lock_cnt_d  = 8'd0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        case (gnt_s)
            GNT_CPU: begin
                last_gnt_d = PORT_CPU;
                rvalid0_d  = ~we0;
                if (!we0) begin
                    rdata0_d = mem_rdata;
                end else begin
                    rdata0_d = rdata0_q;
                end
            end
            GNT_AUX: begin
                last_gnt_d  = PORT_AUX;
                lock_hold_d = lock1;
                rvalid1_d   = ~we1;
                if (!we1) begin
                    rdata1_d = mem_rdata;
                end else begin
                    rdata1_d = rdata1_q;
                end
                // Only grants forced past a waiting CPU consume lock budget.
                if (!lock1) begin
                    lock_cnt_d = 8'd0;
                end else if (lock_hold_q && req0 && (lock_cnt_q < MAX_LOCK_C)) begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end else begin
                    lock_cnt_d = lock_cnt_q;
                end
            end
            default: begin
                last_gnt_d  = last_gnt_q;
                lock_hold_d = 1'b0;
                lock_cnt_d  = 8'd0;
            end
        endcase
    end

    // State register with synchronous reset; port 1 marked last so CPU wins first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q  <= PORT_AUX;
            lock_hold_q <= 1'b0;
            lock_cnt_q  <= 8'd0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= {DATA_W{1'b0}};
            rdata1_q    <= {DATA_W{1'b0}};
        end else begin
            last_gnt_q  <= last_gnt_d;
            lock_hold_q <= lock_hold_d;
            lock_cnt_q  <= lock_cnt_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then random traffic,
// checked against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

    localparam int MAXL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0, addr1 = 32'd0, wdata1 = 32'd0;
    logic        ready0, ready1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ready0(ready0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .ready1(ready1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory driven only by the DUT's memory port.
    logic [31:0] env_mem [0:255];
    assign mem_rdata = env_mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) env_mem[mem_addr[9:2]] <= mem_wdata;

    typedef struct {
        int          cyc;
        int          g;
        bit          known;
        logic        we;
        logic [31:0] addr, wdata;
        bit          rv0, rv1;
        logic [31:0] rd0, rd1;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int          m_last, m_streak, m_prev_gnt;
    bit          m_prev_lock, m_known;
    bit          m_rv [2];
    logic [31:0] m_rd [2];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    // Which port the rules give the memory to this cycle; updates history.
    function automatic int model_grant(bit rst, bit r0, bit r1, bit l1);
        int  g;
        bit  locked;
        if (rst) begin
            m_last = 1; m_streak = 0; m_prev_gnt = -1; m_prev_lock = 1'b0;
            return -1;
        end
        locked = (m_prev_gnt == 1) && m_prev_lock && r1;
        if (r0 && r1) begin
            if (locked && m_streak < MAXL) begin
                g = 1;
                m_streak++;
            end else begin
                g = (m_last == 0) ? 1 : 0;
            end
        end else if (r0) g = 0;
        else if (r1) g = 1;
        else g = -1;
        if (g != 1 || !l1) m_streak = 0;
        if (g >= 0) m_last = g;
        m_prev_gnt  = g;
        m_prev_lock = l1;
        return g;
    endfunction

    task automatic cycle(input bit rst, input bit r0, input bit w0, input logic [31:0] a0,
                         input logic [31:0] d0, input bit r1, input bit w1,
                         input logic [31:0] a1, input logic [31:0] d1, input bit l1,
                         output int g);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        reset = rst; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        e.cyc = cyc; e.known = m_known;
        e.rv0 = m_rv[0]; e.rv1 = m_rv[1]; e.rd0 = m_rd[0]; e.rd1 = m_rd[1];
        g = model_grant(rst, r0, r1, l1);
        e.g = g;
        e.we = 1'b0; e.addr = 32'd0; e.wdata = 32'd0;
        if (g == 0) begin e.we = w0; e.addr = a0; e.wdata = d0; end
        if (g == 1) begin e.we = w1; e.addr = a1; e.wdata = d1; end
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        if (rst) begin
            m_rd[0] = 32'd0; m_rd[1] = 32'd0; m_known = 1'b1;
        end else if (g >= 0) begin
            if (e.we) ref_mem[e.addr[9:2]] = e.wdata;
            else begin
                m_rv[g] = 1'b1;
                m_rd[g] = ref_mem[e.addr[9:2]];
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the expectation queue.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ready0", {31'd0, ready0}, {31'd0, e.g == 0});
            chk("ready1", {31'd0, ready1}, {31'd0, e.g == 1});
            chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_wdata", mem_wdata, e.wdata);
            if (e.known) begin
                chk("rvalid0", {31'd0, rvalid0}, {31'd0, e.rv0});
                chk("rvalid1", {31'd0, rvalid1}, {31'd0, e.rv1});
                chk("rdata0", rdata0, e.rd0);
                chk("rdata1", rdata1, e.rd1);
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        logic [7:0] w;
        w = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        return {22'd0, w, 2'b00};
    endfunction

    initial begin
        int          g;
        bit          p0, p1, w0r, w1r, l1r, rst;
        logic [31:0] a0r, d0r, a1r, d1r, v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        env_mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        m_known = 1'b0; m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = 32'd0; m_rd[1] = 32'd0;
        m_last = 1; m_streak = 0; m_prev_gnt = -1; m_prev_lock = 1'b0;

        repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        // Lone CPU read of 0xDEADBEEF
        cycle(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, g);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        // Round-robin alternation from reset
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        repeat (4) cycle(0, 1, 0, 32'h40, 0, 1, 0, 32'h44, 0, 0, g);
        // Lock burst: port 1 writes 0x55 to 0x20 while CPU waits to read it
        cycle(0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, g);
        cycle(0, 1, 0, 32'h20, 0, 1, 1, 32'h20, 32'h55, 1, g);
        repeat (MAXL) cycle(0, 1, 0, 32'h20, 0, 1, 0, 32'h24, 0, 1, g);
        cycle(0, 1, 0, 32'h20, 0, 1, 0, 32'h24, 0, 1, g);
        cycle(0, 0, 0, 0, 0, 1, 0, 32'h24, 0, 1, g);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        // Reset coinciding with a CPU read, then a contested cycle
        cycle(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, g);
        cycle(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, g);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        cycle(0, 1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0, g);
        cycle(0, 0, 0, 0, 0, 1, 0, 32'h14, 0, 0, g);
        // Idle cycles leave last_gnt untouched
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        cycle(0, 1, 1, 32'h8, 32'h1234, 1, 0, 32'h8, 0, 0, g);
        cycle(0, 1, 1, 32'h8, 32'h1234, 1, 0, 32'h8, 0, 0, g);

        // Random traffic; a losing requester holds its operands.
        p0 = 1'b0; p1 = 1'b0;
        w0r = 1'b0; w1r = 1'b0; a0r = 32'd0; a1r = 32'd0; d0r = 32'd0; d1r = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            if (!p0) begin
                p0 = ($urandom_range(0, 9) < 6);
                w0r = 1'($urandom_range(0, 1)); a0r = rand_addr(); d0r = $urandom;
            end
            if (!p1) begin
                p1 = ($urandom_range(0, 9) < 6);
                w1r = 1'($urandom_range(0, 1)); a1r = rand_addr(); d1r = $urandom;
            end
            l1r = p1 && ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle(rst, p0, w0r, a0r, d0r, p1, w1r, a1r, d1r, l1r, g);
            if (g == 0) p0 = 1'b0;
            if (g == 1) p1 = 1'b0;
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        repeat (3) @(posedge clk);
        chk("drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
